// File: rtl/apb_2_axi4_lite_bridge.sv
// APB4 slave to AXI4-Lite master bridge: one outstanding transfer. Writes complete on the
// B response, AXI SLVERR/DECERR map onto pslverr, and a stalled transfer aborts on timeout.
module apb_2_axi4_lite_bridge #(
   parameter int ADDR_WTH    = 10,
   parameter int DATA_WTH    = 32,
   parameter int TIMEOUT_WTH = 8,
   parameter int ERRCNT_WTH  = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WTH-1:0]     s_apb_paddr,
   input  logic                    s_apb_psel,
   input  logic                    s_apb_penable,
   input  logic                    s_apb_pwrite,
   input  logic [DATA_WTH-1:0]     s_apb_pwdata,
   input  logic [DATA_WTH/8-1:0]   s_apb_pstrb,
   input  logic [2:0]              s_apb_pprot,
   output logic                    s_apb_pready,
   output logic [DATA_WTH-1:0]     s_apb_prdata,
   output logic                    s_apb_pslverr,
   output logic [ADDR_WTH-1:0]     m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WTH-1:0]     m_axi_wdata,
   output logic [DATA_WTH/8-1:0]   m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WTH-1:0]     m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WTH-1:0]     m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [ERRCNT_WTH-1:0]   err_cnt,
   output logic                    timeout_flag,
   input  logic                    timeout_clr
);

   localparam int STRB_WTH = DATA_WTH / 8;
   localparam logic [TIMEOUT_WTH-1:0] TMO_ZERO = {TIMEOUT_WTH{1'b0}};
   localparam logic [TIMEOUT_WTH-1:0] TMO_ONE  = {{(TIMEOUT_WTH-1){1'b0}}, 1'b1};
   // Abort on the edge where the count would reach all-ones.
   localparam logic [TIMEOUT_WTH-1:0] TMO_LAST = {{(TIMEOUT_WTH-1){1'b1}}, 1'b0};
   localparam logic [ERRCNT_WTH-1:0]  ERR_ONE  = {{(ERRCNT_WTH-1){1'b0}}, 1'b1};
   localparam logic [ERRCNT_WTH-1:0]  ERR_MAX  = {ERRCNT_WTH{1'b1}};
   localparam logic [DATA_WTH-1:0]    DATA_ZERO = {DATA_WTH{1'b0}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WREQ  = 3'd1,
      WRESP = 3'd2,
      RREQ  = 3'd3,
      RRESP = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                  state_r, state_s;
   logic [ADDR_WTH-1:0]     addr_r;
   logic [DATA_WTH-1:0]     wdata_r;
   logic [STRB_WTH-1:0]     strb_r;
   logic [2:0]              prot_r;
   logic                    awvalid_r, awvalid_s;
   logic                    wvalid_r, wvalid_s;
   logic                    arvalid_r, arvalid_s;
   logic                    bready_r, bready_s;
   logic                    rready_r, rready_s;
   logic                    err_r, err_s;
   logic                    tmo_r, tmo_s;
   logic [DATA_WTH-1:0]     prdata_r, prdata_s;
   logic [TIMEOUT_WTH-1:0]  cnt_r, cnt_s;
   logic                    cap_s;
   logic                    tlast_s;
   logic                    pready_r;
   logic                    pslverr_r;
   logic [ERRCNT_WTH-1:0]   err_cnt_r;
   logic                    tflag_r;
   logic                    unused_s;

   // Only the error bit of each response is meaningful to APB.
   assign unused_s = ^{m_axi_bresp[0], m_axi_rresp[0]};

   // Next-state, handshake and timeout decode.
   always_comb begin
      state_s   = state_r;
      awvalid_s = awvalid_r;
      wvalid_s  = wvalid_r;
      arvalid_s = arvalid_r;
      bready_s  = 1'b0;
      rready_s  = 1'b0;
      err_s     = err_r;
      tmo_s     = tmo_r;
      prdata_s  = prdata_r;
      cnt_s     = cnt_r;
      cap_s     = 1'b0;
      tlast_s   = (cnt_r == TMO_LAST);
      case (state_r)
         IDLE: begin
            cnt_s = TMO_ZERO;
            if (s_apb_psel && !s_apb_penable) begin
               cap_s = 1'b1;
               err_s = 1'b0;
               tmo_s = 1'b0;
               if (s_apb_pwrite) begin
                  state_s   = WREQ;
                  awvalid_s = 1'b1;
                  wvalid_s  = 1'b1;
               end else begin
                  state_s   = RREQ;
                  arvalid_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WREQ: begin
            cnt_s     = cnt_r + TMO_ONE;
            awvalid_s = awvalid_r & ~m_axi_awready;
            wvalid_s  = wvalid_r & ~m_axi_wready;
            if (tlast_s) begin
               awvalid_s = 1'b0;
               wvalid_s  = 1'b0;
               err_s     = 1'b1;
               tmo_s     = 1'b1;
               state_s   = DONE;
            end else if (!awvalid_s && !wvalid_s) begin
               state_s  = WRESP;
               bready_s = 1'b1;
            end else begin
               state_s = WREQ;
            end
         end
         WRESP: begin
            cnt_s = cnt_r + TMO_ONE;
            // A response arriving on the terminal cycle still counts as a real completion.
            if (m_axi_bvalid) begin
               err_s   = m_axi_bresp[1];
               state_s = DONE;
            end else if (tlast_s) begin
               err_s   = 1'b1;
               tmo_s   = 1'b1;
               state_s = DONE;
            end else begin
               bready_s = 1'b1;
            end
         end
         RREQ: begin
            cnt_s     = cnt_r + TMO_ONE;
            arvalid_s = arvalid_r & ~m_axi_arready;
            if (tlast_s) begin
               arvalid_s = 1'b0;
               err_s     = 1'b1;
               tmo_s     = 1'b1;
               prdata_s  = DATA_ZERO;
               state_s   = DONE;
            end else if (!arvalid_s) begin
               state_s  = RRESP;
               rready_s = 1'b1;
            end else begin
               state_s = RREQ;
            end
         end
         RRESP: begin
            cnt_s = cnt_r + TMO_ONE;
            if (m_axi_rvalid) begin
               prdata_s = m_axi_rdata;
               err_s    = m_axi_rresp[1];
               state_s  = DONE;
            end else if (tlast_s) begin
               prdata_s = DATA_ZERO;
               err_s    = 1'b1;
               tmo_s    = 1'b1;
               state_s  = DONE;
            end else begin
               rready_s = 1'b1;
            end
         end
         DONE: begin
            cnt_s   = TMO_ZERO;
            state_s = IDLE;
         end
         default: begin
            awvalid_s = 1'b0;
            wvalid_s  = 1'b0;
            arvalid_s = 1'b0;
            cnt_s     = TMO_ZERO;
            state_s   = IDLE;
         end
      endcase
   end

   // State, AXI channel registers and captured APB request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= IDLE;
         addr_r    <= {ADDR_WTH{1'b0}};
         wdata_r   <= DATA_ZERO;
         strb_r    <= {STRB_WTH{1'b0}};
         prot_r    <= 3'b000;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         arvalid_r <= 1'b0;
         bready_r  <= 1'b0;
         rready_r  <= 1'b0;
         err_r     <= 1'b0;
         tmo_r     <= 1'b0;
         prdata_r  <= DATA_ZERO;
         cnt_r     <= TMO_ZERO;
      end else begin
         state_r   <= state_s;
         awvalid_r <= awvalid_s;
         wvalid_r  <= wvalid_s;
         arvalid_r <= arvalid_s;
         bready_r  <= bready_s;
         rready_r  <= rready_s;
         err_r     <= err_s;
         tmo_r     <= tmo_s;
         prdata_r  <= prdata_s;
         cnt_r     <= cnt_s;
         if (cap_s) begin
            addr_r  <= s_apb_paddr;
            wdata_r <= s_apb_pwdata;
            strb_r  <= s_apb_pstrb;
            prot_r  <= s_apb_pprot;
         end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            strb_r  <= strb_r;
            prot_r  <= prot_r;
         end
      end
   end

   // APB completion, error counter and sticky timeout flag, all updated as DONE retires.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
         err_cnt_r <= {ERRCNT_WTH{1'b0}};
         tflag_r   <= 1'b0;
      end else begin
         pready_r  <= (state_r == DONE);
         pslverr_r <= (state_r == DONE) & err_r;
         if ((state_r == DONE) && err_r && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_ONE;
         end else begin
            err_cnt_r <= err_cnt_r;
         end
         // A timeout set beats a coincident clear.
         if ((state_r == DONE) && tmo_r) begin
            tflag_r <= 1'b1;
         end else if (timeout_clr) begin
            tflag_r <= 1'b0;
         end else begin
            tflag_r <= tflag_r;
         end
      end
   end

   assign s_apb_pready  = pready_r;
   assign s_apb_pslverr = pslverr_r;
   assign s_apb_prdata  = prdata_r;
   assign m_axi_awaddr  = addr_r;
   assign m_axi_awprot  = prot_r;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_wstrb   = strb_r;
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;
   assign m_axi_araddr  = addr_r;
   assign m_axi_arprot  = prot_r;
   assign m_axi_arvalid = arvalid_r;
   assign m_axi_rready  = rready_r;
   assign err_cnt       = err_cnt_r;
   assign timeout_flag  = tflag_r;

endmodule

// File: tb/tb_apb_2_axi4_lite_bridge.sv
// Randomized bench for the APB to AXI4-Lite bridge (64-bit data, 4-bit timeout/error counters)
// with a delay-programmable AXI slave and a transaction-level reference model.
module tb_apb_2_axi4_lite_bridge;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic          clk;
   logic          rstn;
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;
   logic [3:0]    err_cnt;
   logic          timeout_flag, timeout_clr;

   apb_2_axi4_lite_bridge #(
      .ADDR_WTH(AW), .DATA_WTH(DW), .TIMEOUT_WTH(4), .ERRCNT_WTH(4)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
      .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
      .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .err_cnt(err_cnt), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
   );

   int total, bad;

   // slave programming: cycles each ready/valid waits after the DUT's valid/ready appears
   int            d_aw, d_w, d_b, d_ar, d_r;
   logic [1:0]    b_resp, r_resp;
   logic [DW-1:0] r_data;
   int            aw_n, w_n, b_n, ar_n, r_n;
   int            aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
   logic [AW-1:0] cap_awaddr, cap_araddr;
   logic [2:0]    cap_awprot, cap_arprot;
   logic [DW-1:0] cap_wdata;
   logic [SW-1:0] cap_wstrb;

   // reference model state
   logic [DW-1:0] m_prdata;
   int            m_err_cnt;
   logic          m_tflag;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // AXI4-Lite slave: drives readies/responses on the falling edge from the programmed delays
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      forever begin
         @(negedge clk);
         if (awvalid) begin awready = (aw_n >= d_aw); aw_n++; aw_cyc++; end
         else begin awready = 1'b0; aw_n = 0; end
         if (wvalid) begin wready = (w_n >= d_w); w_n++; w_cyc++; end
         else begin wready = 1'b0; w_n = 0; end
         if (arvalid) begin arready = (ar_n >= d_ar); ar_n++; ar_cyc++; end
         else begin arready = 1'b0; ar_n = 0; end
         if (bready) begin bvalid = (b_n >= d_b); b_n++; b_cyc++; end
         else begin bvalid = 1'b0; b_n = 0; end
         bresp = bvalid ? b_resp : 2'(2'($urandom) & 2'b01);
         if (rready) begin rvalid = (r_n >= d_r); r_n++; r_cyc++; end
         else begin rvalid = 1'b0; r_n = 0; end
         rdata = rvalid ? r_data : {$urandom, $urandom};
         rresp = rvalid ? r_resp : 2'($urandom);
         if (awvalid && awready) begin cap_awaddr = awaddr; cap_awprot = awprot; end
         if (wvalid && wready) begin cap_wdata = wdata; cap_wstrb = wstrb; end
         if (arvalid && arready) begin cap_araddr = araddr; cap_arprot = arprot; end
      end
   end

   // One APB transfer against the programmed slave, checked against the transaction model.
   task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic [2:0] prot,
                           input logic hold_clr, input logic drop_sel);
      int busy, exp_lat, lat, pulses;
      logic tmo, err, got_err;
      busy    = wr ? (((d_aw > d_w) ? d_aw : d_w) + d_b + 2) : (d_ar + d_r + 2);
      tmo     = (busy > 15);
      exp_lat = tmo ? 17 : busy + 2;
      err     = tmo | (wr ? b_resp[1] : r_resp[1]);
      lat = 0; pulses = 0; got_err = 1'bx;
      @(negedge clk);
      aw_cyc = 0; w_cyc = 0; b_cyc = 0; ar_cyc = 0; r_cyc = 0;
      cap_awaddr = 'x; cap_awprot = 'x; cap_wdata = 'x; cap_wstrb = 'x;
      cap_araddr = 'x; cap_arprot = 'x;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      pstrb = strb; pprot = prot; timeout_clr = hold_clr;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) penable = 1'b1;
         if (drop_sel && c == 2) begin psel = 1'b0; penable = 1'b0; end
         if (pready) begin
            pulses++;
            if (lat == 0) begin lat = c; got_err = pslverr; timeout_clr = 1'b0; end
         end
         if (lat != 0 && c == lat + 1) begin psel = 1'b0; penable = 1'b0; end
         if (lat != 0 && c >= lat + 3) break;
      end
      psel = 1'b0; penable = 1'b0; timeout_clr = 1'b0;
      if (!wr) m_prdata = tmo ? '0 : r_data;
      if (err && m_err_cnt < 15) m_err_cnt++;
      m_tflag = tmo ? 1'b1 : (hold_clr ? 1'b0 : m_tflag);
      check_val("pready_latency", 64'(lat), 64'(exp_lat));
      check_val("pready_pulses", 64'(pulses), 64'd1);
      check_val("pslverr", 64'(got_err), 64'(err));
      check_val("prdata", prdata, m_prdata);
      check_val("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
      check_val("timeout_flag", 64'(timeout_flag), 64'(m_tflag));
      if (wr && !tmo) begin
         check_val("awaddr", 64'(cap_awaddr), 64'(addr));
         check_val("awprot", 64'(cap_awprot), 64'(prot));
         check_val("wdata", cap_wdata, data);
         check_val("wstrb", 64'(cap_wstrb), 64'(strb));
         check_val("awvalid_cycles", 64'(aw_cyc), 64'(d_aw + 1));
         check_val("wvalid_cycles", 64'(w_cyc), 64'(d_w + 1));
         check_val("bready_cycles", 64'(b_cyc), 64'(d_b + 1));
         check_val("wr_no_ar", 64'(ar_cyc + r_cyc), 64'd0);
      end
      if (!wr && !tmo) begin
         check_val("araddr", 64'(cap_araddr), 64'(addr));
         check_val("arprot", 64'(cap_arprot), 64'(prot));
         check_val("arvalid_cycles", 64'(ar_cyc), 64'(d_ar + 1));
         check_val("rready_cycles", 64'(r_cyc), 64'(d_r + 1));
         check_val("rd_no_aw", 64'(aw_cyc + w_cyc + b_cyc), 64'd0);
      end
      if (!wr && tmo && d_ar >= 15) check_val("arvalid_tmo_cycles", 64'(ar_cyc), 64'd15);
   endtask

   task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
      d_aw = aw; d_w = w; d_b = b; d_ar = ar; d_r = r;
   endtask

   task automatic pulse_clr();
      @(negedge clk); timeout_clr = 1'b1;
      @(negedge clk); timeout_clr = 1'b0;
      m_tflag = 1'b0;
      check_val("timeout_clr", 64'(timeout_flag), 64'(m_tflag));
   endtask

   initial begin
      total = 0; bad = 0;
      rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pwdata = '0; pstrb = '0; pprot = 3'b000; timeout_clr = 1'b0;
      set_delays(0, 0, 0, 0, 0); b_resp = 2'b00; r_resp = 2'b00; r_data = '0;
      m_prdata = '0; m_err_cnt = 0; m_tflag = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_ctl", 64'({awvalid, wvalid, arvalid, bready, rready, pready, pslverr, timeout_flag}), 64'd0);
      check_val("reset_prdata", prdata, 64'd0);
      check_val("reset_err_cnt", 64'(err_cnt), 64'd0);
      check_val("reset_awaddr", 64'({awaddr, wstrb}), 64'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // zero-wait write
      apb_xfer(1'b1, 10'h0A4, 64'h0000_0000_DEAD_BEEF, 8'h0F, 3'b000, 1'b0, 1'b0);
      // wready well ahead of awready, slow B response
      set_delays(3, 0, 5, 0, 0);
      apb_xfer(1'b1, 10'h1F0, 64'h1111_2222_3333_4444, 8'hFF, 3'b010, 1'b0, 1'b0);
      // read with two-cycle R latency
      set_delays(0, 0, 0, 0, 2); r_data = 64'h0000_0000_1234_5678;
      apb_xfer(1'b0, 10'h010, 64'd0, 8'h00, 3'b001, 1'b0, 1'b0);
      // SLVERR read then DECERR write
      set_delays(0, 0, 1, 1, 0); r_resp = 2'b10; r_data = 64'hA5A5_0000_FFFF_0001;
      apb_xfer(1'b0, 10'h020, 64'd0, 8'h00, 3'b000, 1'b0, 1'b0);
      b_resp = 2'b11;
      apb_xfer(1'b1, 10'h024, 64'h5555_AAAA_5555_AAAA, 8'h3C, 3'b000, 1'b0, 1'b0);
      check_val("err_cnt_two", 64'(err_cnt), 64'd2);
      b_resp = 2'b00; r_resp = 2'b00;
      // read timeout with arready stuck low, then clear
      set_delays(0, 0, 0, 100, 0); r_data = 64'hFFFF_FFFF_FFFF_FFFF;
      apb_xfer(1'b0, 10'h030, 64'd0, 8'h00, 3'b000, 1'b0, 1'b0);
      pulse_clr();
      // write timeout in WRESP with timeout_clr held: set must win
      set_delays(0, 0, 100, 0, 0);
      apb_xfer(1'b1, 10'h034, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 3'b000, 1'b1, 1'b0);
      pulse_clr();
      // upper-lane strobes on the 64-bit bus
      set_delays(0, 0, 0, 0, 0);
      apb_xfer(1'b1, 10'h038, 64'hCAFE_F00D_1234_5678, 8'hF0, 3'b100, 1'b0, 1'b0);

      // reset while waiting in WRESP
      set_delays(0, 0, 100, 0, 0);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h3FC; pwdata = 64'h1; pstrb = 8'h01;
      @(negedge clk); penable = 1'b1;
      for (int c = 0; c < 20 && !bready; c++) @(negedge clk);
      check_val("rst_in_wresp", 64'(bready), 64'd1);
      #2 rstn = 1'b0;
      #1;
      check_val("rst_async_ctl", 64'({awvalid, wvalid, arvalid, bready, rready, pready, pslverr, timeout_flag}), 64'd0);
      check_val("rst_async_prdata", prdata, 64'd0);
      check_val("rst_async_err_cnt", 64'(err_cnt), 64'd0);
      check_val("rst_async_addr", 64'({awaddr, araddr, wstrb}), 64'd0);
      psel = 1'b0; penable = 1'b0;
      m_prdata = '0; m_err_cnt = 0; m_tflag = 1'b0;
      @(negedge clk); rstn = 1'b1;
      set_delays(0, 0, 0, 0, 0); r_data = 64'h0F0F_0F0F_F0F0_F0F0;
      apb_xfer(1'b0, 10'h040, 64'd0, 8'h00, 3'b000, 1'b0, 1'b0);

      // randomized traffic, occasional stalled channel, dropped psel and clears
      for (int i = 0; i < 150; i++) begin
         logic wr;
         int   stuck;
         wr = 1'($urandom);
         set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 5));
         stuck = $urandom_range(0, 9);
         if (stuck == 0) begin if (wr) d_aw = 100; else d_ar = 100; end
         if (stuck == 1) begin if (wr) d_w = 100; else d_r = 100; end
         if (stuck == 2 && wr) d_b = 100;
         b_resp = 2'($urandom); r_resp = 2'($urandom); r_data = {$urandom, $urandom};
         apb_xfer(wr, 10'($urandom), {$urandom, $urandom}, 8'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 5) == 0) pulse_clr();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
